cache_refill_ctrl: RTL and testbench

- Miss-handling sequencer for the direct-mapped data cache.
- Accepts one miss at a time from the cache lookup stage, writes back the dirty victim line, fetches the missing line from memory, then issues a one-cycle install strobe back to the cache.
- Sits between the cache and the single line-wide memory port.
- Asserts busy so the pipeline stalls while a refill is in flight.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_refill_ctrl_if.sv | 31 +++
 rtl/cache_refill_stats.sv | 25 ++
 rtl/cache_refill_ctrl.sv | 135 +++++++++++++
 tb/tb_cache_refill_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, refill FSM states and address split/compose helpers
// for the direct-mapped data cache.
package cache_pkg;

  localparam int ARCH_BITS       = 32;
  localparam int CACHE_LINE_SIZE = 128;
  localparam int LINE_BITS       = 2;
  localparam int OFFSET_BITS     = 4;
  localparam int TAG_BITS        = ARCH_BITS - LINE_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    INSTALL
  } refill_state_t;

  function automatic logic [LINE_BITS-1:0] addr_index(input logic [ARCH_BITS-1:0] addr);
    return addr[OFFSET_BITS +: LINE_BITS];
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ARCH_BITS-1:0] addr);
    return addr[ARCH_BITS-1 -: TAG_BITS];
  endfunction

  function automatic logic [ARCH_BITS-1:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                                     input logic [LINE_BITS-1:0] index);
    return {tag, index, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Line-wide memory port between the refill controller (master) and memory (slave).
// Handshake: mem_req is held with stable mem_we/mem_addr/mem_wdata until the
// one-cycle mem_ack completion pulse; on reads mem_rdata is valid with mem_ack.
interface cache_refill_ctrl_if;

  logic                                 mem_req;
  logic                                 mem_we;
  logic [cache_pkg::ARCH_BITS-1:0]       mem_addr;
  logic [cache_pkg::CACHE_LINE_SIZE-1:0] mem_wdata;
  logic [cache_pkg::CACHE_LINE_SIZE-1:0] mem_rdata;
  logic                                 mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/cache_refill_stats.sv
// Miss and writeback event counters for the refill controller; the module
// exists only when CACHE_REFILL_STATS_EN is defined.
`ifdef CACHE_REFILL_STATS_EN
module cache_refill_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_accept,
  input  logic        wb_ack,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_writebacks
);

  // Both counters wrap naturally modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (miss_accept) stat_misses     <= stat_misses + 32'd1;
      if (wb_ack)      stat_writebacks <= stat_writebacks + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/cache_refill_ctrl.sv
// Miss sequencer: dirty-victim writeback, line fetch, one-cycle install strobe.
// Optional stats counters are built when CACHE_REFILL_STATS_EN is defined.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid,
  output logic                       miss_ready,
  input  logic [ARCH_BITS-1:0]       miss_addr,
  input  logic                       victim_dirty,
  input  logic [TAG_BITS-1:0]        victim_tag,
  input  logic [CACHE_LINE_SIZE-1:0] victim_data,
  output logic                       busy,
  output logic                       fill_valid,
  output logic [LINE_BITS-1:0]       fill_index,
  output logic [TAG_BITS-1:0]        fill_tag,
  output logic [CACHE_LINE_SIZE-1:0] fill_data,
  cache_refill_ctrl_if.master        mem,
`ifdef CACHE_REFILL_STATS_EN
  output logic [31:0]                stat_misses,
  output logic [31:0]                stat_writebacks,
`endif
  output refill_state_t              dbg_state
);

  refill_state_t              state, state_n;
  logic                       accept;
  logic                       mem_req_q, mem_we_q, busy_q, fill_valid_q;
  logic [ARCH_BITS-1:0]       mem_addr_q, mem_addr_n;
  logic [CACHE_LINE_SIZE-1:0] mem_wdata_q, mem_wdata_n;
  logic [LINE_BITS-1:0]       fill_index_q, fill_index_n;
  logic [TAG_BITS-1:0]        fill_tag_q, fill_tag_n;
  logic [CACHE_LINE_SIZE-1:0] fill_data_q, fill_data_n;
  logic                       unused_offset;

  // Byte offset within the line never reaches memory: accesses are line-aligned.
  assign unused_offset = ^miss_addr[OFFSET_BITS-1:0];

  assign miss_ready = (state == IDLE) && !rst;
  assign accept     = miss_valid && miss_ready;

  always_comb begin
    state_n      = state;
    mem_addr_n   = mem_addr_q;
    mem_wdata_n  = mem_wdata_q;
    fill_index_n = fill_index_q;
    fill_tag_n   = fill_tag_q;
    fill_data_n  = fill_data_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          fill_index_n = addr_index(miss_addr);
          fill_tag_n   = addr_tag(miss_addr);
          if (victim_dirty) begin
            state_n     = WB;
            mem_addr_n  = line_addr(victim_tag, addr_index(miss_addr));
            mem_wdata_n = victim_data;
          end else begin
            state_n    = FILL;
            mem_addr_n = line_addr(addr_tag(miss_addr), addr_index(miss_addr));
          end
        end
      end
      WB: begin
        // mem_req stays high into the read phase; only address/direction change.
        if (mem.mem_ack) begin
          state_n    = FILL;
          mem_addr_n = line_addr(fill_tag_q, fill_index_q);
        end
      end
      FILL: begin
        if (mem.mem_ack) begin
          state_n     = INSTALL;
          fill_data_n = mem.mem_rdata;
        end
      end
      INSTALL: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fill_index_q <= '0;
      fill_tag_q   <= '0;
      fill_data_q  <= '0;
    end else begin
      state        <= state_n;
      mem_req_q    <= (state_n == WB) || (state_n == FILL);
      mem_we_q     <= (state_n == WB);
      busy_q       <= (state_n != IDLE);
      fill_valid_q <= (state_n == INSTALL);
      mem_addr_q   <= mem_addr_n;
      mem_wdata_q  <= mem_wdata_n;
      fill_index_q <= fill_index_n;
      fill_tag_q   <= fill_tag_n;
      fill_data_q  <= fill_data_n;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign fill_valid    = fill_valid_q;
  assign fill_index    = fill_index_q;
  assign fill_tag      = fill_tag_q;
  assign fill_data     = fill_data_q;
  assign dbg_state     = state;

`ifdef CACHE_REFILL_STATS_EN
  logic wb_ack;
  assign wb_ack = (state == WB) && mem.mem_ack && !rst;

  cache_refill_stats u_stats (
    .clk             (clk),
    .rst             (rst),
    .miss_accept     (accept),
    .wb_ack          (wb_ack),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
  );
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed and random misses against a memory
// responder and a transaction-level reference model.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                       miss_valid = 1'b0;
  logic                       miss_ready;
  logic [ARCH_BITS-1:0]       miss_addr = '0;
  logic                       victim_dirty = 1'b0;
  logic [TAG_BITS-1:0]        victim_tag = '0;
  logic [CACHE_LINE_SIZE-1:0] victim_data = '0;
  logic                       busy;
  logic                       fill_valid;
  logic [LINE_BITS-1:0]       fill_index;
  logic [TAG_BITS-1:0]        fill_tag;
  logic [CACHE_LINE_SIZE-1:0] fill_data;
  refill_state_t              dbg_state;
`ifdef CACHE_REFILL_STATS_EN
  logic [31:0]                stat_misses;
  logic [31:0]                stat_writebacks;
`endif

  cache_refill_ctrl_if mem ();

  cache_refill_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .miss_valid      (miss_valid),
    .miss_ready      (miss_ready),
    .miss_addr       (miss_addr),
    .victim_dirty    (victim_dirty),
    .victim_tag      (victim_tag),
    .victim_data     (victim_data),
    .busy            (busy),
    .fill_valid      (fill_valid),
    .fill_index      (fill_index),
    .fill_tag        (fill_tag),
    .fill_data       (fill_data),
    .mem             (mem.master),
`ifdef CACHE_REFILL_STATS_EN
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  logic [ARCH_BITS-1:0]       log_addr[$];
  logic                       log_we[$];
  logic [CACHE_LINE_SIZE-1:0] log_wdata[$];

  int                         mem_wait = 0;
  logic [CACHE_LINE_SIZE-1:0] rdata_val = '0;
  bit                         spur_ack = 1'b0;

  task automatic chk(input string tag, input logic [CACHE_LINE_SIZE-1:0] obs,
                     input logic [CACHE_LINE_SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int                         rsp_cnt = 0;
  bit                         prev_wb_ack = 1'b0;
  logic [ARCH_BITS-1:0]       hold_addr;
  logic                       hold_we;
  logic [CACHE_LINE_SIZE-1:0] hold_wdata;

  initial begin
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem.mem_ack) begin
        mem.mem_ack = 1'b0;
        rsp_cnt     = 0;
      end
      if (prev_wb_ack) begin
        chk("req_held_into_read", mem.mem_req, 1'b1);
        prev_wb_ack = 1'b0;
      end
      if (spur_ack) begin
        mem.mem_ack = 1'b1;
        spur_ack    = 1'b0;
      end else if (!mem.mem_req) begin
        rsp_cnt = 0;
      end else begin
        if (rsp_cnt == 0) begin
          hold_addr  = mem.mem_addr;
          hold_we    = mem.mem_we;
          hold_wdata = mem.mem_wdata;
        end else begin
          chk("stable_addr", mem.mem_addr, hold_addr);
          chk("stable_we", mem.mem_we, hold_we);
          if (hold_we) chk("stable_wdata", mem.mem_wdata, hold_wdata);
        end
        if (rsp_cnt == mem_wait) begin
          mem.mem_ack   = 1'b1;
          mem.mem_rdata = mem.mem_we ? {$urandom, $urandom, $urandom, $urandom} : rdata_val;
          log_addr.push_back(mem.mem_addr);
          log_we.push_back(mem.mem_we);
          log_wdata.push_back(mem.mem_wdata);
          prev_wb_ack = mem.mem_we;
        end else begin
          rsp_cnt++;
        end
      end
    end
  end

  // ---------------- driver: one miss, checked against the model ----------------
  // Called at a negedge while idle; returns at a negedge while idle.
  task automatic do_miss(input logic [ARCH_BITS-1:0] addr, input logic dirty,
                         input logic [TAG_BITS-1:0] vtag,
                         input logic [CACHE_LINE_SIZE-1:0] vdata,
                         input int wait_c, input bit hold);
    logic [ARCH_BITS-1:0]       exp_addr[$];
    logic                       exp_we[$];
    logic [CACHE_LINE_SIZE-1:0] exp_wdata[$];
    int                         exp_fill;
    int                         idx;
    bit                         done;

    idx      = int'((addr / 16) % 4);
    exp_fill = 1 + (dirty ? wait_c + 1 : 0) + wait_c + 1;
    if (dirty) begin
      exp_addr.push_back((ARCH_BITS'(vtag) << 6) | ARCH_BITS'(idx << 4));
      exp_we.push_back(1'b1);
      exp_wdata.push_back(vdata);
    end
    exp_addr.push_back(addr & ~32'hF);
    exp_we.push_back(1'b0);
    exp_wdata.push_back('0);

    mem_wait  = wait_c;
    rdata_val = {$urandom, $urandom, $urandom, $urandom};
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();

    chk("ready_idle", miss_ready, 1'b1);
    miss_valid   = 1'b1;
    miss_addr    = addr;
    victim_dirty = dirty;
    victim_tag   = vtag;
    victim_data  = vdata;

    done = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      if (!hold) miss_valid = 1'b0;
      chk("busy_in_flight", busy, 1'b1);
      chk("ready_low_busy", miss_ready, 1'b0);
      if (fill_valid) begin
        done = 1'b1;
        chk("fill_cycle", c, exp_fill);
        chk("fill_index", fill_index, idx);
        chk("fill_tag", fill_tag, addr / 64);
        chk("fill_data", fill_data, rdata_val);
        chk("no_req_install", mem.mem_req, 1'b0);
        miss_valid = 1'b0;
      end
    end
    if (!done) chk("fill_timeout", 1'b0, 1'b1);

    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("ready_after", miss_ready, 1'b1);
    chk("single_fill", fill_valid, 1'b0);
    chk("req_after", mem.mem_req, 1'b0);

    chk("txn_count", log_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
      chk("txn_addr", log_addr[i], exp_addr[i]);
      chk("txn_we", log_we[i], exp_we[i]);
      if (exp_we[i]) chk("txn_wdata", log_wdata[i], exp_wdata[i]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem.mem_req, 1'b0);
    chk("rst_mem_we", mem.mem_we, 1'b0);
    chk("rst_fill_valid", fill_valid, 1'b0);
    chk("rst_mem_addr", mem.mem_addr, '0);
    chk("rst_mem_wdata", mem.mem_wdata, '0);
    chk("rst_fill_data", fill_data, '0);
    chk("rst_ready", miss_ready, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);

    // Clean miss, ack in the first request cycle.
    do_miss(32'h0000_1234, 1'b0, '0, '0, 0, 1'b0);
    // Dirty miss: writeback to 0x50 then read 0x2010.
    do_miss(32'h0000_2010, 1'b1, 26'h1, {4{32'h1111_1111}}, 0, 1'b0);
    // Memory stall in both phases: busy for 13 cycles.
    do_miss(32'h0000_3A70, 1'b1, 26'h2_BEEF, {4{32'hDEAD_BEEF}}, 5, 1'b0);

    // Back-to-back with miss_valid held through the refill.
    do_miss(32'h0000_4420, 1'b0, '0, '0, 1, 1'b1);
    do_miss(32'h0001_0030, 1'b1, 26'h3F, {4{32'hCAFE_F00D}}, 2, 1'b1);

    // Spurious ack in IDLE.
    spur_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spur_busy", busy, 1'b0);
      chk("spur_req", mem.mem_req, 1'b0);
      chk("spur_ready", miss_ready, 1'b1);
    end

    // Randomized misses.
    for (int i = 0; i < 10; i++) begin
      do_miss($urandom, 1'($urandom_range(0, 1)), TAG_BITS'($urandom),
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset during FILL with wait=3.
    mem_wait     = 3;
    miss_valid   = 1'b1;
    miss_addr    = 32'h0000_5550;
    victim_dirty = 1'b0;
    @(negedge clk);
    miss_valid = 1'b0;
    chk("pre_rst_req", mem.mem_req, 1'b1);
    @(negedge clk);
    chk("pre_rst_state", dbg_state, FILL);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", dbg_state, IDLE);
    chk("mid_rst_req", mem.mem_req, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_fill", fill_valid, 1'b0);
    chk("mid_rst_ready", miss_ready, 1'b0);
`ifdef CACHE_REFILL_STATS_EN
    chk("stat_misses_rst", stat_misses, '0);
    chk("stat_wb_rst", stat_writebacks, '0);
`endif
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_fill", fill_valid, 1'b0);
      chk("post_rst_idle", busy, 1'b0);
    end

    do_miss(32'h0000_6660, 1'b0, '0, '0, 0, 1'b0);
    do_miss(32'h0000_7770, 1'b1, 26'h55, {4{32'h0F0F_0F0F}}, 1, 1'b0);
`ifdef CACHE_REFILL_STATS_EN
    chk("stat_misses", stat_misses, 32'd2);
    chk("stat_writebacks", stat_writebacks, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
